// File: rtl/uart_pkg.sv
// Definitions shared by the UART receive and transmit paths: FSM state
// encodings, parity group size and a parity-bit-count helper.
package uart_pkg;

  localparam int GROUP_SIZE = 8;

  typedef logic [2:0] uart_state_t;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_DATA    = 3'd1;
  localparam logic [2:0] ST_PARITY  = 3'd2;
  localparam logic [2:0] ST_STOP    = 3'd3;
  localparam logic [2:0] ST_RECOVER = 3'd4;

  // Parity bits in a frame: one per (possibly partial) group, or one overall.
  function automatic int parity_bits(input int width, input logic pf);
    return pf ? (width + GROUP_SIZE - 1) / GROUP_SIZE : 1;
  endfunction

endpackage

// File: rtl/rx_path.sv
// Bit-synchronous UART receiver: start, LSB-first data, even parity per
// 8-bit group or per frame, one stop bit. All outputs are registered.
module rx_path
  import uart_pkg::*;
#(
  parameter int WIDTH_SIZE = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Rx,
  input  logic                  PF,
  output logic [WIDTH_SIZE-1:0] data_out,
  output logic                  valid_out,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  busy,
  output logic [2:0]            state_dbg
);

  localparam int IW = $clog2(WIDTH_SIZE + 1);
  localparam int GW = $clog2(GROUP_SIZE);
  localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH_SIZE - 1);
  localparam logic [IW-1:0] IDX_ALL  = IW'(WIDTH_SIZE);
  localparam logic [GW-1:0] GRP_LAST = GW'(GROUP_SIZE - 1);

  uart_state_t           state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [GW-1:0]         grp_q, grp_d;
  logic                  acc_q, acc_d;
  logic                  pf_q, pf_d;
  logic                  perr_q, perr_d;
  logic [WIDTH_SIZE-1:0] shift_q, shift_d;
  logic [WIDTH_SIZE-1:0] data_out_q, data_out_d;
  logic                  valid_q, valid_d;
  logic                  perr_out_q, perr_out_d;
  logic                  ferr_out_q, ferr_out_d;
  logic                  busy_q, busy_d;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    grp_d      = grp_q;
    acc_d      = acc_q;
    pf_d       = pf_q;
    perr_d     = perr_q;
    shift_d    = shift_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    perr_out_d = perr_out_q;
    ferr_out_d = ferr_out_q;

    case (state_q)
      ST_IDLE: begin
        if (!Rx) begin
          state_d = ST_DATA;
          pf_d    = PF;
          idx_d   = '0;
          grp_d   = '0;
          acc_d   = 1'b0;
          perr_d  = 1'b0;
        end
      end
      ST_DATA: begin
        // Right shift places the first (LSB) bit at position 0 after the last bit.
        shift_d = WIDTH_SIZE'({Rx, shift_q} >> 1);
        idx_d   = idx_q + IW'(1);
        grp_d   = grp_q + GW'(1);
        acc_d   = acc_q ^ Rx;
        if (idx_q == IDX_LAST || (pf_q && grp_q == GRP_LAST)) begin
          state_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (Rx != acc_q) perr_d = 1'b1;
        acc_d   = 1'b0;
        state_d = (idx_q == IDX_ALL) ? ST_STOP : ST_DATA;
      end
      ST_STOP: begin
        data_out_d = shift_q;
        perr_out_d = perr_q;
        ferr_out_d = !Rx;
        valid_d    = 1'b1;
        state_d    = Rx ? ST_IDLE : ST_RECOVER;
      end
      ST_RECOVER: begin
        if (Rx) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      grp_q      <= '0;
      acc_q      <= 1'b0;
      pf_q       <= 1'b0;
      perr_q     <= 1'b0;
      shift_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      grp_q      <= grp_d;
      acc_q      <= acc_d;
      pf_q       <= pf_d;
      perr_q     <= perr_d;
      shift_q    <= shift_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
      busy_q     <= busy_d;
    end
  end

  assign data_out   = data_out_q;
  assign valid_out  = valid_q;
  assign parity_err = perr_out_q;
  assign frame_err  = ferr_out_q;
  assign busy       = busy_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_rx_path.sv
// Directed and random frames into 8-bit and 16-bit receivers; expected words,
// error flags and arrival cycles are queued when driven and checked on valid_out.
module tb_rx_path;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx8 = 1'b1, pf8 = 1'b0;
  logic        rx16 = 1'b1, pf16 = 1'b0;
  logic [7:0]  data8;
  logic [15:0] data16;
  logic        valid8, perr8, ferr8, busy8;
  logic        valid16, perr16, ferr16, busy16;
  logic [2:0]  st8, st16;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // {frame_err, parity_err, data} and the cycle at which valid_out must be seen
  logic [33:0] exp8_q[$], exp16_q[$];
  int          lat8_q[$], lat16_q[$];
  logic [31:0] last8, last16;

  rx_path #(.WIDTH_SIZE(8)) dut8 (
    .clk(clk), .reset(rst_n), .Rx(rx8), .PF(pf8),
    .data_out(data8), .valid_out(valid8), .parity_err(perr8),
    .frame_err(ferr8), .busy(busy8), .state_dbg(st8)
  );

  rx_path #(.WIDTH_SIZE(16)) dut16 (
    .clk(clk), .reset(rst_n), .Rx(rx16), .PF(pf16),
    .data_out(data16), .valid_out(valid16), .parity_err(perr16),
    .frame_err(ferr16), .busy(busy16), .state_dbg(st16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input int which, input logic b);
    @(negedge clk);
    if (which == 0) rx8 = b; else rx16 = b;
  endtask

  // Transmitter model: start, data LSB first, even parity bits, stop.
  task automatic send_frame(input int which, input logic [31:0] data, input int w,
                            input logic pf, input logic flip, input logic stop_b,
                            input logic jitter_pf);
    int   pb;
    logic acc;
    logic flip_once;
    logic [31:0] d;
    d  = (w == 32) ? data : (data & ((32'd1 << w) - 1));
    pb = pf ? (w + 7) / 8 : 1;
    @(negedge clk);
    if (which == 0) begin
      rx8 = 1'b0; pf8 = pf;
      exp8_q.push_back({~stop_b, flip, d});
      lat8_q.push_back(cyc + 2 + w + pb);
      last8 = d;
    end else begin
      rx16 = 1'b0; pf16 = pf;
      exp16_q.push_back({~stop_b, flip, d});
      lat16_q.push_back(cyc + 2 + w + pb);
      last16 = d;
    end
    acc = 1'b0;
    flip_once = flip;
    for (int i = 0; i < w; i++) begin
      drive_bit(which, d[i]);
      if (jitter_pf) begin
        if (which == 0) pf8 = 1'($urandom_range(0, 1));
        else pf16 = 1'($urandom_range(0, 1));
      end
      acc = acc ^ d[i];
      if ((pf && (i % 8 == 7)) || i == w - 1) begin
        drive_bit(which, acc ^ flip_once);
        flip_once = 1'b0;
        acc = 1'b0;
      end
    end
    drive_bit(which, stop_b);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp8_q.size() != 0 || exp16_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_queues_empty", 64'(exp8_q.size() + exp16_q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    logic [33:0] e;
    int          t;
    if (valid8 === 1'b1) begin
      if (exp8_q.size() == 0) check("unexpected_valid8", 64'd1, 64'd0);
      else begin
        e = exp8_q.pop_front();
        t = lat8_q.pop_front();
        check("data8", 64'(data8), 64'(e[7:0]));
        check("perr8", 64'(perr8), 64'(e[32]));
        check("ferr8", 64'(ferr8), 64'(e[33]));
        check("latency8", 64'(cyc), 64'(t));
      end
    end
    if (valid16 === 1'b1) begin
      if (exp16_q.size() == 0) check("unexpected_valid16", 64'd1, 64'd0);
      else begin
        e = exp16_q.pop_front();
        t = lat16_q.pop_front();
        check("data16", 64'(data16), 64'(e[15:0]));
        check("perr16", 64'(perr16), 64'(e[32]));
        check("ferr16", 64'(ferr16), 64'(e[33]));
        check("latency16", 64'(cyc), 64'(t));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data8"}, 64'(data8), 64'd0);
    check({tag, "_flags8"}, 64'({valid8, perr8, ferr8, busy8}), 64'd0);
    check({tag, "_data16"}, 64'(data16), 64'd0);
    check({tag, "_flags16"}, 64'({valid16, perr16, ferr16, busy16}), 64'd0);
  endtask

  initial begin
    int which;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // 0xA5, PF=0, good parity; then the same word with a bad parity bit, back to back
    send_frame(0, 32'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(0, 32'hA5, 8, 1'b0, 1'b1, 1'b1, 1'b0);
    // 16-bit grouped and single-parity framing, PF toggling mid-frame
    send_frame(1, 32'h1234, 16, 1'b1, 1'b0, 1'b1, 1'b1);
    send_frame(1, 32'h1234, 16, 1'b0, 1'b0, 1'b1, 1'b1);
    send_frame(1, 32'hBEEF, 16, 1'b1, 1'b1, 1'b1, 1'b0);

    // Low stop bit, line held low through RECOVER, then a clean frame
    send_frame(0, 32'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    send_frame(0, 32'h5A, 8, 1'b1, 1'b0, 1'b1, 1'b0);
    drive_bit(0, 1'b1);
    wait_drain(60);

    // Reset during data bit 4 aborts the frame silently
    drive_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(0, 1'(i & 1));
    @(negedge clk);
    check("busy_mid_frame", 64'(busy8), 64'd1);
    rst_n = 1'b0;
    rx8 = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    rst_n = 1'b1;
    send_frame(0, 32'h81, 8, 1'b0, 1'b0, 1'b1, 1'b0);

    // Loopback on random words and framing, with occasional zero-gap frames
    for (int k = 0; k < 12; k++) begin
      which = int'($urandom_range(0, 1));
      send_frame(which, $urandom, (which == 0) ? 8 : 16, 1'($urandom_range(0, 1)),
                 1'b0, 1'b1, 1'b1);
      repeat ($urandom_range(0, 2)) drive_bit(which, 1'b1);
    end
    drive_bit(0, 1'b1);
    drive_bit(1, 1'b1);
    wait_drain(60);

    repeat (5) @(negedge clk);
    check("hold_data8", 64'(data8), 64'(last8[7:0]));
    check("hold_data16", 64'(data16), 64'(last16[15:0]));
    check("hold_flags", 64'({perr8, ferr8, perr16, ferr16}), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_path.md
RX_PATH -- requirements
Module: rx_path

Interface
REQ-001 Parameter WIDTH_SIZE, default 8, meaning: number of data bits per frame (1..32).
REQ-002 clk  input  1  single clock; one line bit per rising edge (bit-synchronous, no oversampling).
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 Rx  input  1  serial line; idles high.
REQ-005 PF  input  1  parity framing: 1 = one parity bit after every 8-bit group and after the final partial group; 0 = one parity bit after all data bits.
REQ-006 data_out  output  WIDTH_SIZE  last received word, LSB first on the line.
REQ-007 valid_out  output  1  one-cycle pulse marking a completed frame.
REQ-008 parity_err  output  1  parity mismatch in the frame flagged by valid_out.
REQ-009 frame_err  output  1  stop bit sampled low in the frame flagged by valid_out.
REQ-010 busy  output  1  high from start-bit detection until the FSM returns to IDLE.

Function
REQ-011 Frame format: start (0), data bits LSB first, parity bit(s), one stop (1); each bit lasts exactly one clk.
REQ-012 The FSM SHALL have states IDLE, DATA, PARITY, STOP, RECOVER.
- IDLE: Rx==0 -> DATA; PF latched this cycle; bit index, group count and parity accumulator cleared.
- DATA: each cycle, shift Rx into data[index], index+1, accumulate parity (XOR).
  - After the 8th bit of a group with PF=1, or after bit WIDTH_SIZE-1 -> PARITY.
- PARITY: compare Rx with the accumulator (even parity: bit == XOR of covered data bits).
  - Mismatch sets the sticky frame parity flag; accumulator cleared.
  - More data remaining -> DATA, otherwise -> STOP.
- STOP: Rx==1 -> IDLE; Rx==0 -> set frame error, -> RECOVER.
- RECOVER: stay until Rx==1, then -> IDLE; no start detection while in RECOVER.
REQ-013 Parity bit count SHALL be ceil(WIDTH_SIZE/8) when PF=1 and exactly 1 when PF=0.
REQ-014 The latched PF SHALL govern the whole frame; PF changes mid-frame have no effect.
REQ-015 In the cycle after the stop bit is sampled, the block SHALL:
- load data_out;
- drive parity_err and frame_err for the frame;
- pulse valid_out high for exactly one cycle.
All outputs are registered.
REQ-016 data_out, parity_err and frame_err SHALL hold until the next valid_out.
REQ-017 A frame with errors SHALL still deliver data_out and valid_out.
REQ-018 A start bit in the cycle immediately after a good stop bit SHALL be accepted (back-to-back frames, zero idle gap).
REQ-019 A frame that starts immediately SHALL NOT disturb the valid_out pulse of the previous frame.
REQ-020 Total frame latency: start-bit edge to valid_out = 1 + WIDTH_SIZE + parity bits + 1 cycles.

Reset
REQ-021 While reset==0:
- FSM in IDLE; index, group count and accumulator cleared;
- data_out=0, valid_out=0, parity_err=0, frame_err=0, busy=0.
REQ-022 Reset asserted mid-frame SHALL abort the frame without a valid_out pulse.
REQ-023 After reset release, the first low on Rx SHALL be treated as a start bit.

Structure
REQ-024 State enum and the 8-bit group-size constant SHALL live in the shared package uart_pkg, which the transmit path also uses.
REQ-025 No sub-module: parity accumulation and the shift register stay inline.
REQ-026 Index width SHALL be $clog2(WIDTH_SIZE+1).

Verification
REQ-027 WIDTH_SIZE=8, PF=0, line 0,1,0,1,0,0,1,0,1,0,1 -> data_out=0xA5, parity_err=0, frame_err=0, valid_out pulse 11 cycles after the start edge.
REQ-028 Same frame with parity bit 1 (transmitter err asserted) -> data_out=0xA5, parity_err=1.
REQ-029 WIDTH_SIZE=16, PF=1, data 0x1234 -> parity 1 after the low byte, parity 0 after the high byte; both correct -> data_out=0x1234, no errors.
REQ-030 WIDTH_SIZE=16, PF=0, data 0x1234 -> single parity bit 1 after all 16 data bits; no errors.
REQ-031 Stop bit 0, then Rx low for 3 cycles -> frame_err=1 with valid_out; a start bit during RECOVER is ignored; Rx high -> next frame received correctly.
REQ-032 Reset pulsed at data bit 4 -> no valid_out, outputs zero; the following frame decodes correctly.
REQ-033 Loopback with the transmit path on random data and PF -> every word matches and no errors are flagged.
